dot_product_unit: RTL and testbench



---
 rtl/dot_product_unit_pkg.sv | 18 +
 rtl/dot_product_unit_if.sv | 32 +++
 rtl/dot_product_unit_lib.sv | 57 +++++
 rtl/dot_product_unit.sv | 101 ++++++++++
 tb/tb_dot_product_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dot_product_unit_pkg.sv
// Shared types and defaults for the streaming dot-product engine.
// Holds the FSM encoding and the accumulator-width sanity check.
package dp_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dp_state_t;

   localparam int DP_WIDTH     = 16;
   localparam int DP_ACC_WIDTH = 40;
   localparam int DP_LEN_WIDTH = 10;

   // The accumulator must at least hold one full-precision product.
   function automatic bit acc_width_ok(input int width, input int acc_width);
      return acc_width >= 2 * width;
   endfunction

   localparam bit DP_ACC_OK = acc_width_ok(DP_WIDTH, DP_ACC_WIDTH);

endpackage

// File: rtl/dot_product_unit_if.sv
// Operand/result handshake bundle between operand fetch, the dot-product
// engine and write-back.
interface dot_product_unit_if
   import dp_pkg::*;
#(
   parameter int WIDTH     = DP_WIDTH,
   parameter int ACC_WIDTH = DP_ACC_WIDTH,
   parameter int LEN_WIDTH = DP_LEN_WIDTH
) ();

   logic                 start;
   logic [LEN_WIDTH-1:0] len;
   logic [WIDTH-1:0]     a_data;
   logic [WIDTH-1:0]     b_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;

   modport master (
      output start, len, a_data, b_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, busy
   );

   modport slave (
      input  start, len, a_data, b_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, busy
   );

endinterface

// File: rtl/dot_product_unit_lib.sv
// Small datapath primitives: loadable down-counter, enabled register and
// clearable accumulator. All reset synchronously to zero.
module Counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)       count <= '0;
      else if (load) count <= load_val;
      else if (dec)  count <= count - WIDTH'(1);
   end

endmodule

module Register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

module Accum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] addend,
   output logic [WIDTH-1:0] sum
);

   // Modulo-2^WIDTH add; overflow wraps silently.
   always_ff @(posedge clk) begin
      if (rst)        sum <= '0;
      else if (clear) sum <= '0;
      else if (en)    sum <= sum + addend;
   end

endmodule

// File: rtl/dot_product_unit.sv
// Streaming signed dot-product: multiply each accepted A/B beat into a
// product register, accumulate one cycle later, present the sum in DONE.
module dot_product_unit
   import dp_pkg::*;
#(
   parameter int WIDTH     = DP_WIDTH,
   parameter int ACC_WIDTH = DP_ACC_WIDTH,
   parameter int LEN_WIDTH = DP_LEN_WIDTH
) (
   input logic               clock,
   input logic               reset,
   dot_product_unit_if.slave bus
);

   dp_state_t state, state_nxt;

   logic                        accept, start_go, last_beat, prod_vld;
   logic                        in_ready, out_valid, busy;
   logic [LEN_WIDTH-1:0]        beats_left;
   logic signed [WIDTH-1:0]     a_s, b_s;
   logic signed [2*WIDTH-1:0]   prod_d, prod_q;
   logic signed [ACC_WIDTH-1:0] prod_ext, acc;

   assign a_s       = bus.a_data;
   assign b_s       = bus.b_data;
   assign prod_d    = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);
   assign prod_ext  = ACC_WIDTH'(prod_q);

   assign start_go  = (state == IDLE) && bus.start;
   assign accept    = (state == RUN) && bus.in_valid;
   assign last_beat = accept && (beats_left == LEN_WIDTH'(1));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.start) state_nxt = (bus.len != '0) ? RUN : DONE;
         end
         RUN: begin
            in_ready = 1'b1;
            if (last_beat) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   Counter #(.WIDTH(LEN_WIDTH)) u_beats (
      .clk      (clock),
      .rst      (reset),
      .load     (start_go),
      .dec      (accept),
      .load_val (bus.len),
      .count    (beats_left)
   );

   Register #(.WIDTH(2*WIDTH)) u_prod (
      .clk (clock),
      .rst (reset),
      .en  (accept),
      .d   (prod_d),
      .q   (prod_q)
   );

   // Tags the product register as holding a not-yet-accumulated term.
   Register #(.WIDTH(1)) u_prod_vld (
      .clk (clock),
      .rst (reset),
      .en  (1'b1),
      .d   (accept),
      .q   (prod_vld)
   );

   Accum #(.WIDTH(ACC_WIDTH)) u_acc (
      .clk    (clock),
      .rst    (reset),
      .clear  (start_go),
      .en     (prod_vld),
      .addend (prod_ext),
      .sum    (acc)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.out_data  = acc;

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed bench for dot_product_unit: expected sums queued at start,
// popped and compared at the result handshake.
module tb_dot_product_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   logic [39:0] sb[$];
   int          qa[$];
   int          qb[$];
   bit          vpat[$];

   dot_product_unit_if #(.WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(10)) bus ();

   dot_product_unit #(.WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(10)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_busy"},      64'(bus.busy),      64'd0);
      check({tag, "_out_data"},  64'(bus.out_data),  64'd0);
   endtask

   // One complete vector: start, beats per vpat (default valid), optional
   // stall in DONE, then the result handshake.
   task automatic run_vec(input string tag, input int n, input int stall,
                          input bit poke_start, input logic [39:0] exp);
      int       idx;
      int       cyc;
      bit       v;
      logic [39:0] want;
      sb.push_back(exp);
      bus.start = 1'b1;
      bus.len   = 10'(n);
      tick();
      bus.start = 1'b0;
      bus.len   = 10'(3 * n + 5);
      if (n == 0) begin
         check({tag, "_zero_in_ready"}, 64'(bus.in_ready), 64'd0);
      end else begin
         check({tag, "_busy"}, 64'(bus.busy), 64'd1);
         idx = 0;
         cyc = 0;
         while (idx < n && cyc < 200) begin
            v = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
            bus.in_valid = v;
            bus.a_data   = v ? 16'(qa[idx]) : 16'($urandom);
            bus.b_data   = v ? 16'(qb[idx]) : 16'($urandom);
            if (poke_start && cyc == 1) begin
               bus.start = 1'b1;
               bus.len   = 10'd7;
            end else begin
               bus.start = 1'b0;
            end
            check({tag, "_run_in_ready"}, 64'(bus.in_ready), 64'd1);
            if (v) idx++;
            tick();
            cyc++;
         end
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         check({tag, "_beats"}, 64'(idx), 64'(n));
         check({tag, "_drain_in_ready"}, 64'(bus.in_ready), 64'd0);
         check({tag, "_drain_out_valid"}, 64'(bus.out_valid), 64'd0);
         tick();
      end
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_done_in_ready"}, 64'(bus.in_ready), 64'd0);
      for (int s = 0; s < stall; s++) begin
         bus.out_ready = 1'b0;
         check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, "_stall_data"}, 64'(bus.out_data), 64'(sb[0]));
         tick();
      end
      bus.out_ready = 1'b1;
      if (sb.size() > 0) want = sb.pop_front();
      else               want = 'x;
      check({tag, "_out_data"}, 64'(bus.out_data), 64'(want));
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.a_data    = '0;
      bus.b_data    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      check_reset_outputs("reset");

      qa = {1, 2, 3, 4};
      qb = {5, 6, 7, 8};
      vpat = {};
      run_vec("basic", 4, 0, 1'b0, 40'd70);

      qa = {-3, 32767, -32768};
      qb = {4, -1, -32768};
      run_vec("extremes", 3, 0, 1'b0, 40'd1073709045);

      run_vec("len0", 0, 0, 1'b0, 40'd0);

      qa = {100, -200, 300};
      qb = {-5, 6, 7};
      vpat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run_vec("toggle", 3, 5, 1'b0, 40'd400);

      qa = {10, 20, 30};
      qb = {3, 4, -5};
      vpat = {};
      run_vec("poke", 3, 0, 1'b1, 40'hFFFFFFFFD8);

      // Abort a vector after two of four beats.
      bus.start = 1'b1;
      bus.len   = 10'd4;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.a_data   = 16'(i + 9);
         bus.b_data   = 16'(i + 11);
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("midrun_reset");

      qa = {7};
      qb = {6};
      run_vec("after_reset", 1, 0, 1'b0, 40'd42);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
